// File: rtl/mem_bus_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_master_if                                                     |
// | Request/response handshake and memory control strobes for the        |
// | shared data-memory bus initiator.                                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface mem_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        CS;
   logic        WE;
   logic [31:0] ADDR;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, CS, WE, ADDR
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, CS, WE, ADDR
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_bus_master                                                        |
// | Single-outstanding load/store initiator for the shared data memory;  |
// | owns Mem_Bus direction. Option: MEMBUS_WRITE_VERIFY_EN adds a        |
// | readback-and-compare cycle after every store.                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_bus_master #(
   parameter int DEPTH = 128
) (
   input  wire               CLK,
   input  wire               RST_N,
   mem_bus_master_if.master  bus,
   inout  wire  [31:0]       Mem_Bus
);

   localparam logic [31:0] c_depth = 32'(DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      RESP  = 3'd3
`ifdef MEMBUS_WRITE_VERIFY_EN
      ,
      VREAD = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic        cs_q, cs_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cs_d    = cs_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wdata_d = bus.req_wdata;
               rdata_d = 32'd0;
               err_d   = 1'b0;
               // Out-of-range requests never touch the bus; ADDR keeps its old value.
               if (bus.req_addr >= c_depth) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  cs_d    = 1'b1;
                  we_d    = bus.req_we;
                  addr_d  = bus.req_addr;
                  state_d = bus.req_we ? WRITE : READ;
               end
            end
         end
         READ: begin
            rdata_d = Mem_Bus;
            cs_d    = 1'b0;
            state_d = RESP;
         end
         WRITE: begin
            we_d = 1'b0;
`ifdef MEMBUS_WRITE_VERIFY_EN
            // Keep CS up and turn the bus around so the memory drives the readback.
            state_d = VREAD;
`else
            cs_d    = 1'b0;
            state_d = RESP;
`endif
         end
`ifdef MEMBUS_WRITE_VERIFY_EN
         VREAD: begin
            err_d   = (Mem_Bus != wdata_q);
            cs_d    = 1'b0;
            state_d = RESP;
         end
`endif
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.CS        = cs_q;
   assign bus.WE        = we_q;
   assign bus.ADDR      = addr_q;

   // Driven only from registered strobes, so it can never overlap the memory's read drive.
   assign Mem_Bus = (cs_q && we_q) ? wdata_q : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_bus_master                                                     |
// | Directed and randomized load/store traffic against a word-array      |
// | memory model, checked against a reference copy of memory contents.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_bus_master;

   localparam int DEPTH = 128;
`ifdef MEMBUS_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   wire  [31:0] Mem_Bus;
   logic        ignore_writes = 1'b0;
   logic        mem_init_q = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] tb_mem  [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   mem_bus_master_if bus_if ();

   mem_bus_master #(.DEPTH(DEPTH)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .bus     (bus_if.master),
      .Mem_Bus (Mem_Bus)
   );

   always #5 CLK = ~CLK;

   // Memory array: drives reads combinationally, samples writes on the negedge.
   assign Mem_Bus = (bus_if.CS && !bus_if.WE) ? tb_mem[bus_if.ADDR[6:0]] : 32'bz;

   always @(negedge CLK) begin
      if (!mem_init_q) begin
         for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 32'hC0DE0000 + 32'(i);
         mem_init_q <= 1'b1;
      end else if (bus_if.CS && bus_if.WE && !ignore_writes) begin
         tb_mem[bus_if.ADDR[6:0]] <= Mem_Bus;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request at a negedge and follows it through to response acceptance.
   task automatic run_op(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          lat;
      int          cs_cnt;
      if (addr >= DEPTH) begin
         exp_rdata = 32'd0;
         exp_err   = 1'b1;
         exp_lat   = 0;
      end else if (we) begin
         exp_rdata = 32'd0;
         exp_err   = VERIFY && ignore_writes && (ref_mem[addr[6:0]] != wdata);
         exp_lat   = VERIFY ? 2 : 1;
         if (!ignore_writes) ref_mem[addr[6:0]] = wdata;
      end else begin
         exp_rdata = ref_mem[addr[6:0]];
         exp_err   = 1'b0;
         exp_lat   = 1;
      end

      chk("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = we;
      bus_if.req_addr  = addr;
      bus_if.req_wdata = wdata;
      @(posedge CLK);
      #1 bus_if.req_valid = 1'b0;
      @(negedge CLK);

      lat    = 0;
      cs_cnt = 0;
      while (!bus_if.rsp_valid && lat < 8) begin
         if (bus_if.CS) begin
            cs_cnt++;
            chk("addr_during_cs", bus_if.ADDR, addr);
            if (bus_if.WE) chk("bus_wdata", Mem_Bus, wdata);
         end
         chk("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
         lat++;
         @(negedge CLK);
      end
      chk("rsp_latency", 32'(lat), 32'(exp_lat));
      chk("cs_cycles", 32'(cs_cnt), 32'(exp_lat));
      chk("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
      chk("rsp_err", 32'(bus_if.rsp_err), 32'(exp_err));
      chk("cs_in_resp", 32'({bus_if.CS, bus_if.WE}), 32'd0);

      for (int d = 0; d < delay; d++) begin
         @(negedge CLK);
         chk("rsp_valid_hold", 32'(bus_if.rsp_valid), 32'd1);
         chk("rsp_rdata_hold", bus_if.rsp_rdata, exp_rdata);
         chk("rsp_err_hold", 32'(bus_if.rsp_err), 32'(exp_err));
         chk("req_ready_hold", 32'(bus_if.req_ready), 32'd0);
      end

      bus_if.rsp_ready = 1'b1;
      @(posedge CLK);
      #1 bus_if.rsp_ready = 1'b0;
      @(negedge CLK);
      chk("rsp_valid_after_accept", 32'(bus_if.rsp_valid), 32'd0);
   endtask

   initial begin
      int mism;
      logic        r_we;
      logic [31:0] r_addr;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);
      bus_if.req_valid = 1'b0;
      bus_if.req_we    = 1'b0;
      bus_if.req_addr  = 32'd0;
      bus_if.req_wdata = 32'd0;
      bus_if.rsp_ready = 1'b0;

      #2 RST_N = 1'b0;
      @(negedge CLK);
      chk("rst_cs", 32'(bus_if.CS), 32'd0);
      chk("rst_we", 32'(bus_if.WE), 32'd0);
      chk("rst_addr", bus_if.ADDR, 32'd0);
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
      chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      run_op(1'b1, 32'd5, 32'hDEADBEEF, 0);
      run_op(1'b0, 32'd5, 32'd0, 0);

      run_op(1'b0, 32'd200, 32'd0, 1);
      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
      chk("mem_intact_after_oor", 32'(mism), 32'd0);

      run_op(1'b0, 32'd0, 32'd0, 4);

      // Reset landing between the store's accepting edge and its write negedge.
      run_op(1'b1, 32'd9, 32'h0BADF00D, 0);
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = 1'b1;
      bus_if.req_addr  = 32'd9;
      bus_if.req_wdata = 32'h12345678;
      @(posedge CLK);
      #1 bus_if.req_valid = 1'b0;
      chk("store_started", 32'({bus_if.CS, bus_if.WE}), 32'd3);
      #1 RST_N = 1'b0;
      #1;
      chk("midrst_cs_we", 32'({bus_if.CS, bus_if.WE}), 32'd0);
      chk("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("midrst_addr", bus_if.ADDR, 32'd0);
      chk("midrst_req_ready", 32'(bus_if.req_ready), 32'd1);
      @(negedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      run_op(1'b0, 32'd9, 32'd0, 0);

      for (int n = 0; n < 40; n++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_addr = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 500))
                                              : 32'($urandom_range(0, 15));
         run_op(r_we, r_addr, $urandom, int'($urandom_range(0, 3)));
      end

      ignore_writes = 1'b1;
      run_op(1'b1, 32'd3, 32'hA5A5A5A5, 0);
      ignore_writes = 1'b0;
      run_op(1'b0, 32'd3, 32'd0, 0);

      mism = 0;
      for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
      chk("mem_final", 32'(mism), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
